fwrisc_bus_arb: RTL and testbench

Two-port arbiter sharing a single external memory bus between the fwrisc instruction-fetch port and the data port driven by `fwrisc_mem`. It sits between the core and the system memory/interconnect. It serialises one outstanding transaction at a time, registers the selected request onto the shared bus, and routes the response handshake back to the winning requester.

---
 rtl/fwrisc_bus_arb.sv | 145 ++++++++++++++
 tb/tb_fwrisc_bus_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_bus_arb.sv
// fwrisc_bus_arb: shares one registered memory bus between fetch and data ports.
// Define FWRISC_BUS_ARB_RR_EN for round-robin; default is data-over-fetch priority.
module fwrisc_bus_arb (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ivalid,
    input  logic [31:0] iaddr,
    output logic [31:0] idata,
    output logic        iready,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwstb,
    input  logic        dwrite,
    output logic [31:0] drdata,
    output logic        dready,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstb,
    output logic        m_write,
    input  logic [31:0] m_rdata,
    input  logic        m_ready
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_mask_i, w_mask_i_nxt;
    logic        r_mask_d, w_mask_d_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_wstb, w_wstb_nxt;
    logic        r_write, w_write_nxt;
    logic        w_elig_i, w_elig_d, w_pick_d;
`ifdef FWRISC_BUS_ARB_RR_EN
    logic        r_last, w_last_nxt;  // 1: data port was granted last
`endif

    // The just-served port sits out one IDLE cycle so a late valid drop is not re-granted
    assign w_elig_i = ivalid && !r_mask_i;
    assign w_elig_d = dvalid && !r_mask_d;
`ifdef FWRISC_BUS_ARB_RR_EN
    assign w_pick_d = w_elig_d && (!w_elig_i || !r_last);
`else
    assign w_pick_d = w_elig_d;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_mask_i_nxt = 1'b0;
        w_mask_d_nxt = 1'b0;
        w_valid_nxt  = r_valid;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_wstb_nxt   = r_wstb;
        w_write_nxt  = r_write;
`ifdef FWRISC_BUS_ARB_RR_EN
        w_last_nxt   = r_last;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_pick_d) begin
                    w_state_nxt = GNT_D;
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = daddr;
                    w_wdata_nxt = dwdata;
                    w_wstb_nxt  = dwstb;
                    w_write_nxt = dwrite;
`ifdef FWRISC_BUS_ARB_RR_EN
                    w_last_nxt  = 1'b1;
`endif
                end else if (w_elig_i) begin
                    w_state_nxt = GNT_I;
                    w_valid_nxt = 1'b1;
                    w_addr_nxt  = iaddr;
                    w_wdata_nxt = 32'h0;
                    w_wstb_nxt  = 4'h0;
                    w_write_nxt = 1'b0;
`ifdef FWRISC_BUS_ARB_RR_EN
                    w_last_nxt  = 1'b0;
`endif
                end
            end
            GNT_I: begin
                if (m_ready) begin
                    w_state_nxt  = IDLE;
                    w_valid_nxt  = 1'b0;
                    w_wstb_nxt   = 4'h0;
                    w_write_nxt  = 1'b0;
                    w_mask_i_nxt = 1'b1;
                end
            end
            GNT_D: begin
                if (m_ready) begin
                    w_state_nxt  = IDLE;
                    w_valid_nxt  = 1'b0;
                    w_wstb_nxt   = 4'h0;
                    w_write_nxt  = 1'b0;
                    w_mask_d_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_mask_i <= 1'b0;
            r_mask_d <= 1'b0;
            r_valid  <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_wstb   <= 4'h0;
            r_write  <= 1'b0;
`ifdef FWRISC_BUS_ARB_RR_EN
            r_last   <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_mask_i <= w_mask_i_nxt;
            r_mask_d <= w_mask_d_nxt;
            r_valid  <= w_valid_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wstb   <= w_wstb_nxt;
            r_write  <= w_write_nxt;
`ifdef FWRISC_BUS_ARB_RR_EN
            r_last   <= w_last_nxt;
`endif
        end
    end

    assign m_valid = r_valid;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign m_wstb  = r_wstb;
    assign m_write = r_write;
    assign idata   = m_rdata;
    assign drdata  = m_rdata;
    assign iready  = m_ready && (r_state == GNT_I);
    assign dready  = m_ready && (r_state == GNT_D);

endmodule

// File: tb/tb_fwrisc_bus_arb.sv
// tb_fwrisc_bus_arb: scoreboard bench with a bus responder and auto-requesters.
// Expected grant order follows FWRISC_BUS_ARB_RR_EN when defined.
module tb_fwrisc_bus_arb;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ivalid = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic [31:0] idata;
    logic        iready;
    logic        dvalid = 1'b0;
    logic [31:0] daddr = 32'h0;
    logic [31:0] dwdata = 32'h0;
    logic [3:0]  dwstb = 4'h0;
    logic        dwrite = 1'b0;
    logic [31:0] drdata;
    logic        dready;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstb;
    logic        m_write;
    logic [31:0] m_rdata = 32'h0;
    logic        m_ready = 1'b0;

    fwrisc_bus_arb u_dut (
        .clock(clock), .reset_n(reset_n),
        .ivalid(ivalid), .iaddr(iaddr), .idata(idata), .iready(iready),
        .dvalid(dvalid), .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb),
        .dwrite(dwrite), .drdata(drdata), .dready(dready),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstb(m_wstb), .m_write(m_write), .m_rdata(m_rdata),
        .m_ready(m_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstb;
        logic        write;
    } req_t;

    req_t        qi[$];
    req_t        qd[$];
    logic        ord_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_done = 0;
    int          lat = 0;
    int          cnt = 0;
    logic        rd_fix = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          i_left = 0;
    int          d_left = 0;
    int          i_drop = 0;
    int          d_drop = 0;
    logic        hold = 1'b0;
    longint      cyc = 0;
    longint      last_done = 0;
    longint      prev_done = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_i(input logic [31:0] a, input int n);
        iaddr  = a;
        ivalid = 1'b1;
        i_left = n;
        qi.push_back('{a, 32'h0, 4'h0, 1'b0});
    endtask

    task automatic start_d(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic wr, input int n);
        daddr  = a;
        dwdata = wd;
        dwstb  = st;
        dwrite = wr;
        dvalid = 1'b1;
        d_left = n;
        qd.push_back('{a, wd, st, wr});
    endtask

    task automatic bus_complete();
        req_t        e;
        logic        p;
        logic [31:0] rd;
        rd = rd_fix ? rd_val : $urandom;
        m_rdata = rd;
        m_ready = 1'b1;
        #1;
        chk("rdy_onehot", iready ^ dready, 1);
        p = dready;
        e = '0;
        if (p) begin
            chk("d_qsize", qd.size(), 1);
            if (qd.size() > 0) e = qd.pop_front();
            chk("drdata", drdata, rd);
        end else begin
            chk("i_qsize", qi.size(), 1);
            if (qi.size() > 0) e = qi.pop_front();
            chk("idata", idata, rd);
        end
        chk("m_addr", m_addr, e.addr);
        chk("m_wdata", m_wdata, e.wdata);
        chk("m_wstb", m_wstb, e.wstb);
        chk("m_write", m_write, e.write);
        if (ord_q.size() > 0) chk("order", p, ord_q.pop_front());
        if (p) begin
            d_left--;
            if (d_left <= 0) d_drop = hold ? 2 : 1;
            else begin
                daddr  = daddr + 4;
                dwdata = $urandom;
                dwstb  = 4'($urandom_range(15, 0));
                dwrite = ~dwrite;
                qd.push_back('{daddr, dwdata, dwstb, dwrite});
            end
        end else begin
            i_left--;
            if (i_left <= 0) i_drop = hold ? 2 : 1;
            else begin
                iaddr = iaddr + 4;
                qi.push_back('{iaddr, 32'h0, 4'h0, 1'b0});
            end
        end
        prev_done = last_done;
        last_done = cyc;
        n_done++;
    endtask

    // Bus slave plus requesters that hold valid until served
    initial begin
        forever begin
            @(negedge clock);
            if (i_drop > 0) begin
                i_drop--;
                if (i_drop == 0) ivalid = 1'b0;
            end
            if (d_drop > 0) begin
                d_drop--;
                if (d_drop == 0) dvalid = 1'b0;
            end
            if (m_ready) m_ready = 1'b0;
            else if (!reset_n) cnt = 0;
            else if (m_valid) begin
                if (cnt < lat) cnt++;
                else begin
                    cnt = 0;
                    bus_complete();
                end
            end
        end
    end

    task automatic wait_done(input int n);
        int k = 0;
        while (n_done < n && k < 60) begin
            @(posedge clock);
            k++;
        end
        chk("wait_done", n_done >= n, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int base;
        idle(2);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_wstb", m_wstb, 0);
        chk("rst_m_write", m_write, 0);
        #2 m_ready = 1'b1;
        #1;
        chk("rst_iready", iready, 0);
        chk("rst_dready", dready, 0);
        m_ready = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;

        // both ports, sustained, instant bus: alternate starting with D
        @(negedge clock);
        lat = 0;
        base = n_done;
        start_d(32'h1000, 32'h11111111, 4'hf, 1'b1, 3);
        start_i(32'h0, 3);
        repeat (3) begin
            ord_q.push_back(1'b1);
            ord_q.push_back(1'b0);
        end
        wait_done(base + 6);
        idle(4);

        // single fetch, bus answers 2 cycles after m_valid
        lat = 2;
        rd_fix = 1'b1;
        rd_val = 32'h00000013;
        base = n_done;
        start_i(32'h100, 1);
        #1 chk("fetch_pre", m_valid, 0);
        @(negedge clock);
        chk("fetch_lat", m_valid, 1);
        wait_done(base + 1);
        @(negedge clock);
        chk("fetch_post", m_valid, 0);
        rd_fix = 1'b0;
        idle(3);

        // single data write
        lat = 1;
        base = n_done;
        start_d(32'h2004, 32'hA5A5A5A5, 4'b0011, 1'b1, 1);
        ord_q.push_back(1'b1);
        wait_done(base + 1);
        idle(3);

        // simultaneous after a data grant
        lat = 0;
        base = n_done;
        start_d(32'h3000, 32'h0badf00d, 4'h5, 1'b0, 1);
        start_i(32'h200, 1);
`ifdef FWRISC_BUS_ARB_RR_EN
        ord_q.push_back(1'b0);
        ord_q.push_back(1'b1);
`else
        ord_q.push_back(1'b1);
        ord_q.push_back(1'b0);
`endif
        wait_done(base + 2);
        idle(3);

        // mask: D holds valid a cycle past dready, nothing else pending
        hold = 1'b1;
        base = n_done;
        start_d(32'h4000, 32'hcafe0001, 4'hf, 1'b1, 1);
        wait_done(base + 1);
        repeat (4) begin
            @(negedge clock);
            chk("mask_no_regrant", m_valid, 0);
        end
        chk("mask_count", n_done, base + 1);
        idle(2);

        // mask with fetch waiting: I granted in the masked cycle
        lat = 2;
        base = n_done;
        start_d(32'h5000, 32'h12345678, 4'h3, 1'b0, 1);
        ord_q.push_back(1'b1);
        ord_q.push_back(1'b0);
        @(negedge clock);
        start_i(32'h300, 1);
        wait_done(base + 2);
        chk("mask_turn", last_done - prev_done, 4);
        hold = 1'b0;
        idle(4);

        // m_ready while idle is ignored
        #2 m_ready = 1'b1;
        #1;
        chk("idle_iready", iready, 0);
        chk("idle_dready", dready, 0);
        @(negedge clock);
        chk("idle_m_valid", m_valid, 0);
        idle(2);

        // async reset mid-transaction, then re-grant
        lat = 10;
        base = n_done;
        start_d(32'h6000, 32'hdeadbeef, 4'hc, 1'b1, 1);
        idle(3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_dready", dready, 0);
        chk("arst_m_addr", m_addr, 0);
        @(negedge clock);
        lat = 1;
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("arst_regrant", m_valid, 1);
        wait_done(base + 1);
        idle(4);
        chk("qi_empty", qi.size(), 0);
        chk("qd_empty", qd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
